// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct constants, ALU operation codes and the bundled control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_BOOT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_IMMEXEC  = 4'd9,
    S_IMMWB    = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  typedef struct packed {
    logic       initial_sel;
    logic       pc_write;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       pc_src;
  } ctrl_t;

  // Every state starts from this word and only raises what it needs.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c             = '0;
    c.alu_control = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation decode; flags funct codes the datapath
// does not implement so the FSM can reject the instruction.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       funct_legal_o
);

  always_comb begin
    alu_ctrl_o    = ALU_ADD;
    funct_legal_o = 1'b1;
    case (funct_i)
      FUNCT_ADD: alu_ctrl_o = ALU_ADD;
      FUNCT_SUB: alu_ctrl_o = ALU_SUB;
      FUNCT_AND: alu_ctrl_o = ALU_AND;
      FUNCT_OR:  alu_ctrl_o = ALU_OR;
      FUNCT_NOR: alu_ctrl_o = ALU_NOR;
      default:   funct_legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the multicycle MIPS datapath: boot-loads the PC, steps each
// instruction through fetch/decode/execute states and counts retired instructions.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OP_i,
  input  logic [5:0]           Funct_i,
  output logic                 initial_sel,
  output logic                 PCWrite,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [3:0]           ALUControl,
  output logic                 PCSrc,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] retired_o,
  output logic [3:0]           state_o
);

  state_e               state_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] retired_q;
  logic [3:0]           funct_alu;
  logic                 funct_legal;
  ctrl_t                ctrl;

  alu_decoder u_alu_decoder (
    .funct_i       (Funct_i),
    .alu_ctrl_o    (funct_alu),
    .funct_legal_o (funct_legal)
  );

  // State, illegal pulse and retire counter share one sequential block; the
  // write-back states always exit to FETCH, so being in one means it retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_BOOT;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_BOOT:   state_q <= S_FETCH;
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          if (OP_i == OP_RTYPE && funct_legal) begin
            state_q <= S_EXECUTE;
          end else if (OP_i == OP_LW || OP_i == OP_SW) begin
            state_q <= S_MEMADR;
          end else if (OP_i == OP_ADDI || OP_i == OP_ORI) begin
            state_q <= S_IMMEXEC;
          end else begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b1;
          end
        end
        S_MEMADR:  state_q <= (OP_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD: state_q <= S_MEMWB;
        S_EXECUTE: state_q <= S_ALUWB;
        S_IMMEXEC: state_q <= S_IMMWB;
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_IMMWB: begin
          state_q   <= S_FETCH;
          retired_q <= retired_q + CNT_WIDTH'(1);
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl = ctrl_idle();
    case (state_q)
      S_BOOT: begin
        ctrl.initial_sel = 1'b0;
        ctrl.pc_write    = 1'b1;
      end
      S_FETCH: begin
        ctrl.initial_sel = 1'b1;
        ctrl.iord        = 1'b0;
        ctrl.ir_write    = 1'b1;
        ctrl.alu_src_a   = 1'b0;
        ctrl.alu_src_b   = SRCB_FOUR;
        ctrl.pc_src      = 1'b0;
        ctrl.pc_write    = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMMSH2;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_REG;
        ctrl.alu_control = funct_alu;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      S_IMMEXEC: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src_b   = SRCB_IMM;
        ctrl.alu_control = (OP_i == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IMMWB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      default: ctrl = ctrl_idle();
    endcase
  end

  assign initial_sel = ctrl.initial_sel;
  assign PCWrite     = ctrl.pc_write;
  assign IorD        = ctrl.iord;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUControl  = ctrl.alu_control;
  assign PCSrc       = ctrl.pc_src;

  assign illegal_o = illegal_q;
  assign retired_o = retired_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: table of instructions with expected
// state walks and control words, plus reset and counter-wrap corner cases.
module tb_multicycle_control_unit;
  import mips_ctrl_pkg::*;

  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic [5:0]    OP_i;
  logic [5:0]    Funct_i;
  logic          initial_sel, PCWrite, IorD, MemWrite, IRWrite;
  logic          RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc;
  logic [1:0]    ALUSrcB;
  logic [3:0]    ALUControl;
  logic          illegal_o;
  logic [CW-1:0] retired_o;
  logic [3:0]    state_o;

  multicycle_control_unit #(.CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .OP_i        (OP_i),
    .Funct_i     (Funct_i),
    .initial_sel (initial_sel),
    .PCWrite     (PCWrite),
    .IorD        (IorD),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUControl  (ALUControl),
    .PCSrc       (PCSrc),
    .illegal_o   (illegal_o),
    .retired_o   (retired_o),
    .state_o     (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    int         len;
    logic [3:0] st [5];
    logic [3:0] alu;
    logic       illegal;
    logic       retire;
  } vec_t;

  vec_t          vecs [12];
  int            n_tests;
  int            n_failed;
  logic [CW-1:0] exp_ret;
  logic [CW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pack(input logic isel, input logic pcw, input logic iord,
                                       input logic memw, input logic irw, input logic rdst,
                                       input logic m2r, input logic regw, input logic srca,
                                       input logic [1:0] srcb, input logic [3:0] alu,
                                       input logic pcsrc);
    return {isel, pcw, iord, memw, irw, rdst, m2r, regw, srca, srcb, alu, pcsrc};
  endfunction

  // Control word each state must produce, written out from the state table.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [3:0] alu);
    case (st)
      S_BOOT:     return pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010, 0);
      S_FETCH:    return pack(1, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 4'b0010, 0);
      S_DECODE:   return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0010, 0);
      S_MEMADR:   return pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 0);
      S_MEMREAD:  return pack(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010, 0);
      S_MEMWB:    return pack(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'b0010, 0);
      S_MEMWRITE: return pack(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0010, 0);
      S_EXECUTE:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, alu, 0);
      S_ALUWB:    return pack(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 4'b0010, 0);
      S_IMMEXEC:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, alu, 0);
      S_IMMWB:    return pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0010, 0);
      default:    return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010, 0);
    endcase
  endfunction

  function automatic logic [15:0] act_ctrl();
    return {initial_sel, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
            ALUSrcA, ALUSrcB, ALUControl, PCSrc};
  endfunction

  task automatic add_vec(input int i, input logic [5:0] op, input logic [5:0] funct,
                         input int len, input logic [3:0] s2, input logic [3:0] s3,
                         input logic [3:0] s4, input logic [3:0] alu, input logic ill);
    vecs[i].op      = op;
    vecs[i].funct   = funct;
    vecs[i].len     = len;
    vecs[i].st[0]   = S_FETCH;
    vecs[i].st[1]   = S_DECODE;
    vecs[i].st[2]   = s2;
    vecs[i].st[3]   = s3;
    vecs[i].st[4]   = s4;
    vecs[i].alu     = alu;
    vecs[i].illegal = ill;
    vecs[i].retire  = !ill;
  endtask

  // driver: entered at a negedge with the DUT in FETCH
  task automatic run_vec(input int i);
    logic [3:0] st;
    OP_i    = vecs[i].op;
    Funct_i = vecs[i].funct;
    for (int k = 0; k < vecs[i].len; k++) begin
      if (k > 0) @(negedge clk);
      st = vecs[i].st[k];
      check($sformatf("v%0d_state_c%0d", i, k), 32'(state_o), 32'(st));
      check($sformatf("v%0d_ctrl_c%0d", i, k), 32'(act_ctrl()), 32'(exp_ctrl(st, vecs[i].alu)));
      check($sformatf("v%0d_wen_onehot_c%0d", i, k),
            32'(int'(RegWrite) + int'(MemWrite) + int'(IRWrite) > 1), 32'd0);
      if (k > 0) check($sformatf("v%0d_illegal_c%0d", i, k), 32'(illegal_o), 32'd0);
    end
    @(negedge clk);
    check($sformatf("v%0d_back_to_fetch", i), 32'(state_o), 32'(S_FETCH));
    check($sformatf("v%0d_illegal_pulse", i), 32'(illegal_o), 32'(vecs[i].illegal));
    if (vecs[i].retire) exp_ret = exp_ret + 1'b1;
    exp_q.push_back(exp_ret);
    check($sformatf("v%0d_retired", i), 32'(retired_o), 32'(exp_q.pop_front()));
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    exp_ret  = '0;
    reset    = 1'b0;
    OP_i     = 6'd0;
    Funct_i  = 6'd0;

    add_vec(0,  6'b000000, 6'b100010, 4, S_EXECUTE, S_ALUWB,    S_FETCH, 4'b0110, 0);
    add_vec(1,  6'b000000, 6'b100000, 4, S_EXECUTE, S_ALUWB,    S_FETCH, 4'b0010, 0);
    add_vec(2,  6'b000000, 6'b100100, 4, S_EXECUTE, S_ALUWB,    S_FETCH, 4'b0000, 0);
    add_vec(3,  6'b000000, 6'b100101, 4, S_EXECUTE, S_ALUWB,    S_FETCH, 4'b0001, 0);
    add_vec(4,  6'b000000, 6'b100111, 4, S_EXECUTE, S_ALUWB,    S_FETCH, 4'b1100, 0);
    add_vec(5,  6'b100011, 6'b010101, 5, S_MEMADR,  S_MEMREAD,  S_MEMWB, 4'b0010, 0);
    add_vec(6,  6'b101011, 6'b100010, 4, S_MEMADR,  S_MEMWRITE, S_FETCH, 4'b0010, 0);
    add_vec(7,  6'b001000, 6'b100111, 4, S_IMMEXEC, S_IMMWB,    S_FETCH, 4'b0010, 0);
    add_vec(8,  6'b001101, 6'b100010, 4, S_IMMEXEC, S_IMMWB,    S_FETCH, 4'b0001, 0);
    add_vec(9,  6'b111111, 6'b100000, 2, S_FETCH,   S_FETCH,    S_FETCH, 4'b0010, 1);
    add_vec(10, 6'b000000, 6'b000000, 2, S_FETCH,   S_FETCH,    S_FETCH, 4'b0010, 1);
    add_vec(11, 6'b000100, 6'b100000, 2, S_FETCH,   S_FETCH,    S_FETCH, 4'b0010, 1);

    // held in reset: BOOT decode, cleared status
    repeat (2) @(negedge clk);
    check("reset_state", 32'(state_o), 32'(S_BOOT));
    check("reset_ctrl", 32'(act_ctrl()), 32'(exp_ctrl(S_BOOT, 4'b0010)));
    check("reset_illegal", 32'(illegal_o), 32'd0);
    check("reset_retired", 32'(retired_o), 32'd0);

    reset = 1'b1;
    #1;
    check("boot_hold", 32'(state_o), 32'(S_BOOT));
    @(negedge clk);
    check("boot_to_fetch", 32'(state_o), 32'(S_FETCH));
    check("fetch_pcwrite_isel", 32'({PCWrite, initial_sel}), 32'b11);

    // nine retiring instructions wrap the 3-bit counter through zero
    for (int i = 0; i < 12; i++) run_vec(i);

    // reset in the middle of a load
    OP_i    = 6'b100011;
    Funct_i = 6'b000000;
    repeat (3) @(negedge clk);
    check("midrst_in_memread", 32'(state_o), 32'(S_MEMREAD));
    reset = 1'b0;
    #1;
    check("midrst_state", 32'(state_o), 32'(S_BOOT));
    check("midrst_ctrl", 32'(act_ctrl()), 32'(exp_ctrl(S_BOOT, 4'b0010)));
    check("midrst_wen", 32'({RegWrite, MemWrite, IRWrite, PCWrite}), 32'b0001);
    check("midrst_retired", 32'(retired_o), 32'd0);
    @(negedge clk);
    check("midrst_hold_boot", 32'(state_o), 32'(S_BOOT));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_refetch", 32'(state_o), 32'(S_FETCH));
    exp_ret = '0;
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
